alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised W-bit successor to the 8-bit combinational ALU and its separate carry register.
- Merges the datapath and a full flag register (CY, Z, N, V) into one clocked block with a start/busy/done handshake.
- Adds carry-chaining from the registered CY flag, shift-through-carry ops, signed overflow, and a multi-cycle shift-add multiplier.
- Sits between the register file and the accumulator/flag consumers of the CPU control unit.

Parameters:
- W, 8, operand/result width; legal range 2 to 32.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request an operation; sampled only while busy=0
- op  input  4  operation code, captured with start
- a  input  W  operand A, captured with start
- b  input  W  operand B, captured with start
- ci  input  1  external carry-in
- cin_sel  input  1  1: carry-in = registered CY flag; 0: carry-in = ci
- flag_we  input  1  1: flags update at completion; captured with start
- busy  output  1  multiply in progress; start is ignored while high
- done  output  1  one-cycle pulse: out/out_hi/flags hold a new result
- out  output  W  result (low half of product for MUL)
- out_hi  output  W  high half of product for MUL; 0 for all other ops
- cy  output  1  carry/borrow flag
- z  output  1  zero flag
- n  output  1  negative flag
- v  output  1  signed overflow flag

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, out=0, out_hi=0, cy=z=n=v=0; multiply counter and partial product cleared.
- Reset mid-multiply: the operation is aborted and no done is produced.
- Effective carry-in: cin = cin_sel ? cy : ci, evaluated at the start edge.
- Op codes, width rules, all arithmetic in W+1 bits:
  - 0000 ADD: out = a+b+cin; cy = bit W.
  - 0001 SUB: out = a-b-cin; cy = borrow (1 when a < b+cin, unsigned).
  - 0010 AND, 0011 OR, 0100 XOR: bitwise; cy=0.
  - 0101 NOT: out = ~a; cy=0.
  - 0110 SHL: out = {a[W-2:0],cin}; cy = a[W-1].
  - 0111 SHR: out = {cin,a[W-1:1]}; cy = a[0].
  - 1000 MUL: unsigned {out_hi,out} = a*b; cy = (out_hi != 0).
  - all others PASS: out = b; cy = cin.
- Flags:
  - z = result==0; for MUL, z=1 only when the full 2W-bit product is 0.
  - n = result MSB; for MUL, n = out_hi[W-1].
  - v = signed overflow for ADD/SUB; v=0 for all other ops.
- FSM states: IDLE, MUL.
- IDLE, start=1, op≠MUL:
  - Result registered at the start edge.
  - done=1 during the following cycle only (latency 1); busy stays 0.
  - A new start is accepted in that same done cycle (back-to-back throughput 1 op/cycle).
- IDLE, start=1, op=MUL:
  - Capture a, b, flag_we; clear the accumulator; counter = W-1; go to MUL; busy=1 from the next cycle.
- MUL, each cycle:
  - One shift-add step on the LSB of the multiplier; decrement the counter.
  - When the counter = 0: write the product to out_hi/out, update flags, go to IDLE.
  - busy is high for exactly W cycles; done pulses in the cycle after the last step (W cycles after the start edge).
- start while busy=1: ignored; operands are not re-captured and the ongoing multiply is unaffected.
- flag_we=0: out/out_hi still update and done still pulses; cy, z, n, v hold their previous values.
- Outputs hold between completions; done never stays high for two consecutive cycles for the same op.

Test Plan (W=8):
- ADD a=0xFF, b=0x01, ci=0, cin_sel=0, flag_we=1 -> next cycle done=1, out=0x00, cy=1, z=1, n=0, v=0; done low the cycle after.
- SUB a=0x80, b=0x01, ci=0 -> out=0x7F, cy=0, v=1, n=0; then SUB a=0x00, b=0x01 -> out=0xFF, cy=1, n=1.
- Carry chain: ADD 0xFF+0x01 (cy←1), then ADD a=0x00, b=0x00, cin_sel=1 -> out=0x01, cy=0; SHR a=0x01, cin_sel=1 with cy=1 -> out=0x80, cy=1.
- MUL a=0xFF, b=0xFF -> busy high exactly 8 cycles, done 8 cycles after start, out_hi=0xFE, out=0x01, cy=1, z=0, n=1; start ADD pulsed mid-multiply -> ignored, product unchanged.
- flag_we=0: after the first scenario's flags (cy=1, z=1), AND a=0xF0, b=0x0F -> out=0x00, done=1, flags still cy=1, z=1.
- Assert rst_n=0 four cycles into a MUL, release -> busy=0, done=0, out=out_hi=0, all flags 0, no done pulse; subsequent XOR a=0xAA, b=0xFF -> out=0x55 with done after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: W-bit ALU with flag register, carry chaining and a shift-add multiplier behind a start/busy/done handshake.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    input  logic         cin_sel,
    input  logic         flag_we,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out,
    output logic [W-1:0] out_hi,
    output logic         cy,
    output logic         z,
    output logic         n,
    output logic         v
);
    localparam int CW = $clog2(W);
    localparam logic [3:0] OP_MUL = 4'h8;
    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_nx;
    logic [W-1:0] mcand, mq, acc, res;
    logic [CW-1:0] cnt;
    logic [W:0] sum, step;
    logic fwe, cin, res_cy, res_v, go;
    assign busy = state == MUL;
    always_comb begin
        cin = cin_sel ? cy : ci;
        sum = '0;
        res = b;
        res_cy = cin;
        res_v = 1'b0;
        case (op)
            4'h0: begin
                sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                res = sum[W-1:0];
                res_cy = sum[W];
                res_v = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            4'h1: begin
                sum = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
                res = sum[W-1:0];
                res_cy = sum[W];
                res_v = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            4'h2: begin res = a & b; res_cy = 1'b0; end
            4'h3: begin res = a | b; res_cy = 1'b0; end
            4'h4: begin res = a ^ b; res_cy = 1'b0; end
            4'h5: begin res = ~a; res_cy = 1'b0; end
            4'h6: begin res = {a[W-2:0], cin}; res_cy = a[W-1]; end
            4'h7: begin res = {cin, a[W-1:1]}; res_cy = a[0]; end
            default: ;
        endcase
        // Product is {acc, mq}; each step adds the multiplicand on mq[0] and shifts right.
        step = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
        go = start && state == IDLE;
        state_nx = state;
        if (go && op == OP_MUL)
            state_nx = MUL;
        else if (state == MUL && cnt == '0)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done <= 1'b0;
            out <= '0;
            out_hi <= '0;
            {cy, z, n, v} <= '0;
            {mcand, mq, acc} <= '0;
            cnt <= '0;
            fwe <= 1'b0;
        end else begin
            state <= state_nx;
            done <= 1'b0;
            if (go && op == OP_MUL) begin
                mcand <= a;
                mq <= b;
                acc <= '0;
                cnt <= CW'(W - 1);
                fwe <= flag_we;
            end else if (go) begin
                out <= res;
                out_hi <= '0;
                done <= 1'b1;
                if (flag_we) begin
                    cy <= res_cy;
                    z <= res == '0;
                    n <= res[W-1];
                    v <= res_v;
                end
            end else if (state == MUL) begin
                acc <= step[W:1];
                mq <= {step[0], mq[W-1:1]};
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    out <= {step[0], mq[W-1:1]};
                    out_hi <= step[W:1];
                    done <= 1'b1;
                    if (fwe) begin
                        cy <= |step[W:1];
                        z <= ~|{step, mq[W-1:1]};
                        n <= step[W];
                        v <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 8;
    localparam int MOD = 1 << W;
    localparam int MASK = MOD - 1;
    localparam int HALF = 1 << (W - 1);
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ci = 1'b0, cin_sel = 1'b0, flag_we = 1'b0;
    logic [3:0] op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, cy, z, n, v;
    logic [W-1:0] out, out_hi;
    int checks = 0, errors = 0;
    int m_out = 0, m_hi = 0;
    bit m_cy = 0, m_z = 0, m_n = 0, m_v = 0;

    alu_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .ci(ci),
        .cin_sel(cin_sel), .flag_we(flag_we), .busy(busy), .done(done), .out(out),
        .out_hi(out_hi), .cy(cy), .z(z), .n(n), .v(v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag);
        chk({tag, "_out"}, 64'(out), 64'(m_out));
        chk({tag, "_out_hi"}, 64'(out_hi), 64'(m_hi));
        chk({tag, "_flags"}, 64'({cy, z, n, v}), 64'({m_cy, m_z, m_n, m_v}));
    endtask

    function automatic int sgn(input int x);
        return x >= HALF ? x - MOD : x;
    endfunction

    // Drives one op from a negedge and returns at the negedge where its done is visible.
    task automatic do_op(input logic [3:0] o, input int aa, input int bb, input bit c,
                         input bit sel, input bit fw, input bit inject);
        int cin, s, sv, p, e_out, e_hi, k, busy_n;
        bit e_cy, e_v, seen;
        cin = sel ? int'(m_cy) : int'(c);
        start = 1'b1; op = o; a = W'(aa); b = W'(bb); ci = c; cin_sel = sel; flag_we = fw;
        e_hi = 0; e_v = 0; p = 0;
        case (o)
            4'h0: begin
                s = aa + bb + cin; e_out = s & MASK; e_cy = s >= MOD;
                sv = sgn(aa) + sgn(bb) + cin; e_v = sv >= HALF || sv < -HALF;
            end
            4'h1: begin
                s = aa - bb - cin; e_out = s & MASK; e_cy = aa < bb + cin;
                sv = sgn(aa) - sgn(bb) - cin; e_v = sv >= HALF || sv < -HALF;
            end
            4'h2: begin e_out = aa & bb; e_cy = 0; end
            4'h3: begin e_out = aa | bb; e_cy = 0; end
            4'h4: begin e_out = aa ^ bb; e_cy = 0; end
            4'h5: begin e_out = ~aa & MASK; e_cy = 0; end
            4'h6: begin e_out = (aa * 2 + cin) & MASK; e_cy = aa >= HALF; end
            4'h7: begin e_out = aa / 2 + cin * HALF; e_cy = aa % 2 == 1; end
            4'h8: begin p = aa * bb; e_out = p % MOD; e_hi = p / MOD; e_cy = e_hi != 0; end
            default: begin e_out = bb; e_cy = cin != 0; end
        endcase
        m_out = e_out;
        m_hi = e_hi;
        if (fw) begin
            m_cy = e_cy;
            m_z = (o == 4'h8) ? p == 0 : e_out == 0;
            m_n = (o == 4'h8) ? e_hi >= HALF : e_out >= HALF;
            m_v = e_v;
        end
        if (o != 4'h8) begin
            @(negedge clk);
            start = 1'b0;
            chk("op_done", 64'(done), 64'd1);
            chk("op_busy", 64'(busy), 64'd0);
        end else begin
            k = 0; busy_n = 0; seen = 0;
            while (!seen && k < 3 * W + 4) begin
                @(negedge clk);
                k++;
                if (done) seen = 1;
                else begin
                    if (busy) busy_n++;
                    start = inject && k == 3;
                    if (start) begin op = 4'h0; a = W'(1); b = W'(1); end
                end
            end
            start = 1'b0;
            chk("mul_done", 64'(seen), 64'd1);
            chk("mul_latency", 64'(k), 64'(W + 1));
            chk("mul_busy_cycles", 64'(busy_n), 64'(W));
        end
        expect_all("op");
    endtask

    task automatic idle();
        @(negedge clk);
        chk("idle_done", 64'(done), 64'd0);
    endtask

    initial begin
        int dn;
        repeat (2) @(negedge clk);
        chk("rst_state", 64'({busy, done, out, out_hi, cy, z, n, v}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(4'h0, 'hFF, 'h01, 0, 0, 1, 0);
        chk("add_out", 64'(out), 64'h00);
        chk("add_flags", 64'({cy, z, n, v}), 64'b1100);
        idle();
        do_op(4'h2, 'hF0, 'h0F, 0, 0, 0, 0);
        chk("and_hold_flags", 64'({cy, z}), 64'b11);
        idle();
        do_op(4'h1, 'h80, 'h01, 0, 0, 1, 0);
        chk("sub_ovf", 64'({out, cy, v, n}), 64'({8'h7F, 3'b010}));
        do_op(4'h1, 'h00, 'h01, 0, 0, 1, 0);
        chk("sub_borrow", 64'({out, cy, n}), 64'({8'hFF, 2'b11}));
        do_op(4'h0, 'hFF, 'h01, 0, 0, 1, 0);
        do_op(4'h0, 'h00, 'h00, 0, 1, 1, 0);
        chk("chain_add", 64'({out, cy}), 64'({8'h01, 1'b0}));
        do_op(4'h0, 'hFF, 'h01, 0, 0, 1, 0);
        do_op(4'h7, 'h01, 'h00, 0, 1, 1, 0);
        chk("chain_shr", 64'({out, cy}), 64'({8'h80, 1'b1}));
        idle();
        do_op(4'h8, 'hFF, 'hFF, 0, 0, 1, 1);
        chk("mul_ff", 64'({out_hi, out, cy, z, n}), 64'({8'hFE, 8'h01, 3'b101}));
        idle();
        start = 1'b1; op = 4'h8; a = W'(8'h12); b = W'(8'h34); flag_we = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mul", 64'({busy, done, out, out_hi, cy, z, n, v}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_out = 0; m_hi = 0; {m_cy, m_z, m_n, m_v} = '0;
        dn = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("rst_no_done", 64'(dn), 64'd0);
        do_op(4'h4, 'hAA, 'hFF, 0, 0, 1, 0);
        chk("xor_out", 64'(out), 64'h55);
        for (int i = 0; i < 60; i++) begin
            do_op(4'($urandom_range(0, 15)), int'($urandom_range(0, MASK)),
                  int'($urandom_range(0, MASK)), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
